fft_frame_scheduler: RTL and testbench

Sequences pre-emphasised audio samples into overlapping analysis frames for `windowed_fft`. Samples arrive at the 16 kHz sample rate into a dual-port ring buffer. Every `HOP_SIZE` samples, once `WINDOW_SIZE` samples exist, the block waits for the FFT to be ready, then streams the window oldest-first as a burst of one sample per cycle. It sits between the pre-emphasis stage and `windowed_fft`, and replaces the 400-entry shift-register window.

---
 rtl/fft_frame_scheduler.sv | 175 +++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: collects samples into a dual-port ring and, every HOP_SIZE samples once a
// full window exists, streams the most recent WINDOW_SIZE samples oldest-first to windowed_fft.
// Optional feature macro: FFT_FRAME_SCHED_ZERO_PAD_EN (pads each burst with zeros to FFT_SIZE).
module fft_frame_scheduler #(
   parameter int unsigned BIT_WIDTH   = 32,
   parameter int unsigned WINDOW_SIZE = 400,
   parameter int unsigned HOP_SIZE    = 160,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned FFT_SIZE    = 512
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [BIT_WIDTH-1:0] sample_in,
   input  logic                 sample_valid_in,
   input  logic                 fft_ready_in,
   output logic                 fft_start_out,
   output logic [BIT_WIDTH-1:0] fft_sample_out,
   output logic                 fft_sample_valid_out,
   output logic [15:0]          frame_count_out,
   output logic                 overrun_out,
   output logic                 busy_out
);

`ifdef FFT_FRAME_SCHED_ZERO_PAD_EN
   localparam bit ZERO_PAD = 1'b1;
`else
   localparam bit ZERO_PAD = 1'b0;
`endif
   localparam int unsigned BURST_LEN = ZERO_PAD ? FFT_SIZE : WINDOW_SIZE;
   localparam int unsigned FILL_W    = $clog2(WINDOW_SIZE + 1);
   localparam int unsigned HOP_W     = $clog2(HOP_SIZE + 1);
   localparam int unsigned K_W       = $clog2(BURST_LEN + 1);

   localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(WINDOW_SIZE);
   localparam logic [HOP_W-1:0]      HOP_LAST  = HOP_W'(HOP_SIZE - 1);
   // k == K_LAST is the drain cycle: no read issued, last sample is on the output.
   localparam logic [K_W-1:0]        K_LAST    = K_W'(BURST_LEN);
   localparam logic [K_W-1:0]        K_WIN     = K_W'(WINDOW_SIZE);
   localparam logic [ADDR_WIDTH-1:0] WIN_A     = ADDR_WIDTH'(WINDOW_SIZE);

   typedef enum logic [1:0] {StIdle, StWaitFft, StStream} state_e;

   logic [BIT_WIDTH-1:0]  r_ring [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [FILL_W-1:0]     r_fill_cnt;
   logic [HOP_W-1:0]      r_hop_cnt;
   logic                  r_pending;
   logic [ADDR_WIDTH-1:0] r_pend_base;
   logic [ADDR_WIDTH-1:0] r_rd_base;
   logic [K_W-1:0]        r_k;
   state_e                r_state;
   state_e                w_state_next;
   logic                  r_valid;
   logic                  r_start;
   logic [BIT_WIDTH-1:0]  r_sample;
   logic [15:0]           r_frame_cnt;
   logic                  r_overrun;

   logic                  w_boundary;
   logic                  w_take;
   logic                  w_burst_done;
   logic                  w_busy;
   logic                  w_rd_en;
   logic                  w_rd_ring;
   logic [ADDR_WIDTH-1:0] w_wr_next;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   assign w_wr_next  = r_wr_ptr + ADDR_WIDTH'(1);
   assign w_boundary = sample_valid_in &&
                       ((r_fill_cnt == FILL_FULL - FILL_W'(1)) ||
                        ((r_fill_cnt == FILL_FULL) && (r_hop_cnt == HOP_LAST)));
   assign w_rd_en    = (r_state == StStream) && (r_k < K_LAST);
   assign w_rd_ring  = w_rd_en && (r_k < K_WIN);
   assign w_rd_addr  = r_rd_base + ADDR_WIDTH'(r_k);

   // Ring storage write port; contents deliberately survive reset.
   always_ff @(posedge clk_in) begin
      if (sample_valid_in) r_ring[r_wr_ptr] <= sample_in;
   end

   // Write pointer, fill level and hop counter.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
         r_hop_cnt  <= '0;
      end else if (sample_valid_in) begin
         r_wr_ptr <= w_wr_next;
         if (r_fill_cnt != FILL_FULL) begin
            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
         end else begin
            r_hop_cnt <= (r_hop_cnt == HOP_LAST) ? '0 : r_hop_cnt + HOP_W'(1);
         end
      end
   end

   // Single-slot pending frame; a newer boundary displaces an unconsumed one.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_pending   <= 1'b0;
         r_pend_base <= '0;
         r_rd_base   <= '0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_take) r_rd_base <= r_pend_base;
         if (w_boundary) begin
            r_pending   <= 1'b1;
            r_pend_base <= w_wr_next - WIN_A;
            if (r_pending && !w_take) r_overrun <= 1'b1;
         end else if (w_take) begin
            r_pending <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) r_state <= StIdle;
      else         r_state <= w_state_next;
   end

   // FSM next-state and control decode.
   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      w_burst_done = 1'b0;
      w_busy       = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_pending) w_state_next = StWaitFft;
         end
         StWaitFft: begin
            w_busy = 1'b1;
            if (fft_ready_in) begin
               w_take       = 1'b1;
               w_state_next = StStream;
            end
         end
         StStream: begin
            w_busy = 1'b1;
            if (r_k == K_LAST) begin
               w_burst_done = 1'b1;
               w_state_next = r_pending ? StWaitFft : StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Burst counter, registered read data and frame bookkeeping.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_k         <= '0;
         r_valid     <= 1'b0;
         r_start     <= 1'b0;
         r_sample    <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (w_take)       r_k <= '0;
         else if (w_rd_en) r_k <= r_k + K_W'(1);
         r_valid  <= w_rd_en;
         r_start  <= w_rd_en && (r_k == '0);
         r_sample <= w_rd_ring ? r_ring[w_rd_addr] : '0;
         if (w_burst_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign fft_start_out        = r_start;
   assign fft_sample_out       = r_sample;
   assign fft_sample_valid_out = r_valid;
   assign frame_count_out      = r_frame_cnt;
   assign overrun_out          = r_overrun;
   assign busy_out             = w_busy;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler. The reference model keeps the full sample history
// and derives each expected frame from the boundary rule (every HOP after the first full window).
// Honours FFT_FRAME_SCHED_ZERO_PAD_EN for the expected burst length.
module tb_fft_frame_scheduler;
   localparam int unsigned WIN = 400;
   localparam int unsigned HOP = 160;
`ifdef FFT_FRAME_SCHED_ZERO_PAD_EN
   localparam int unsigned BURST = 512;
`else
   localparam int unsigned BURST = 400;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] sample_in;
   logic        sample_valid_in;
   logic        fft_ready_in;
   logic        fft_start_out;
   logic [31:0] fft_sample_out;
   logic        fft_sample_valid_out;
   logic [15:0] frame_count_out;
   logic        overrun_out;
   logic        busy_out;

   fft_frame_scheduler dut (
      .clk_in               (clk_in),
      .rst_in               (rst_in),
      .sample_in            (sample_in),
      .sample_valid_in      (sample_valid_in),
      .fft_ready_in         (fft_ready_in),
      .fft_start_out        (fft_start_out),
      .fft_sample_out       (fft_sample_out),
      .fft_sample_valid_out (fft_sample_valid_out),
      .frame_count_out      (frame_count_out),
      .overrun_out          (overrun_out),
      .busy_out             (busy_out)
   );

   always #5 clk_in = ~clk_in;

   int unsigned cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state.
   logic [31:0] hist[$];
   int unsigned exp_q[$];
   int unsigned n_since = 0;
   bit          ready_hi = 1'b1;
   bit          slot_valid = 1'b0;
   int unsigned slot_base = 0;
   bit          exp_ovr = 1'b0;
   int unsigned wr_cyc = 0;

   // Monitor state.
   int          mon_len = 0;
   int          mon_err = 0;
   int          mon_start_err = 0;
   int          bursts_seen = 0;
   int unsigned first_cyc = 0;

   // Burst collector: compares each streamed sample against the front expected frame.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         mon_len = 0;
      end else if (fft_sample_valid_out === 1'b1) begin
         logic [31:0] e;
         if (mon_len == 0) begin
            first_cyc     = cyc;
            mon_err       = 0;
            mon_start_err = 0;
         end
         if (fft_start_out !== (mon_len == 0)) mon_start_err++;
         if (busy_out !== 1'b1) mon_start_err++;
         if (exp_q.size() > 0) begin
            e = (mon_len < int'(WIN)) ? hist[exp_q[0] + mon_len] : 32'd0;
            if (fft_sample_out !== e) mon_err++;
         end
         mon_len++;
      end else if (mon_len > 0) begin
         check("burst_len", mon_len, BURST);
         check("burst_data_errs", mon_err, 0);
         check("start_busy_errs", mon_start_err, 0);
         check("burst_expected", exp_q.size() > 0, 1);
         check("busy_after_burst", busy_out, 0);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         bursts_seen++;
         mon_len = 0;
      end else if (fft_start_out === 1'b1) begin
         check("stray_start", 1, 0);
      end
   end

   task automatic write_sample(input logic [31:0] v, input int gap);
      sample_in       = v;
      sample_valid_in = 1'b1;
      wr_cyc          = cyc;
      hist.push_back(v);
      n_since++;
      if (n_since == WIN || (n_since > WIN && (n_since - WIN) % HOP == 0)) begin
         if (ready_hi) begin
            exp_q.push_back(hist.size() - WIN);
         end else begin
            if (slot_valid) exp_ovr = 1'b1;
            slot_base  = hist.size() - WIN;
            slot_valid = 1'b1;
         end
      end
      @(posedge clk_in); #1;
      sample_valid_in = 1'b0;
      repeat (gap - 1) begin @(posedge clk_in); #1; end
   endtask

   task automatic apply_reset();
      rst_in = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      check("rst_valid", fft_sample_valid_out, 0);
      check("rst_start", fft_start_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_overrun", overrun_out, 0);
      check("rst_frame_count", frame_count_out, 0);
      check("rst_sample", fft_sample_out, 0);
      n_since    = 0;
      slot_valid = 1'b0;
      exp_ovr    = 1'b0;
      exp_q.delete();
      #1 rst_in = 1'b1;
      @(posedge clk_in); #1;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy_out !== 1'b0) && n < budget) begin
         @(posedge clk_in); #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int b0;
      rst_in          = 1'b0;
      sample_in       = '0;
      sample_valid_in = 1'b0;
      fft_ready_in    = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      apply_reset();

      // Sequential values, 50-cycle spacing: first frame, then one hop later.
      b0 = bursts_seen;
      for (int i = 0; i < 400; i++) write_sample(32'(i), 50);
      wait_drain(2000);
      check("s1_bursts", bursts_seen - b0, 1);
      check("s1_latency", first_cyc - wr_cyc, 4);
      check("s1_frame_count", frame_count_out, 1);
      for (int i = 400; i < 560; i++) write_sample(32'(i), 50);
      wait_drain(2000);
      check("s2_bursts", bursts_seen - b0, 2);
      check("s2_frame_count", frame_count_out, 2);
      check("s2_overrun", overrun_out, 0);

      // FFT not ready across two boundaries: only the newest window streams.
      apply_reset();
      fft_ready_in = 1'b0;
      ready_hi     = 1'b0;
      b0 = bursts_seen;
      for (int i = 0; i < 560; i++) write_sample($urandom, $urandom_range(3, 6));
      repeat (20) @(posedge clk_in);
      #1;
      check("s3_no_burst", bursts_seen - b0, 0);
      check("s3_busy_waiting", busy_out, 1);
      check("s3_overrun", overrun_out, exp_ovr);
      fft_ready_in = 1'b1;
      ready_hi     = 1'b1;
      if (slot_valid) exp_q.push_back(slot_base);
      slot_valid = 1'b0;
      wait_drain(2000);
      check("s3_bursts", bursts_seen - b0, 1);
      check("s3_frame_count", frame_count_out, 1);

      // Reset in the middle of a burst.
      apply_reset();
      b0 = bursts_seen;
      for (int i = 0; i < 400; i++) write_sample($urandom, $urandom_range(3, 6));
      begin
         int n = 0;
         while (mon_len < 200 && n < 2000) begin @(negedge clk_in); #1; n++; end
         check("s4_reached_mid_burst", mon_len, 200);
      end
      apply_reset();
      check("s4_aborted_not_counted", bursts_seen - b0, 0);
      for (int i = 0; i < 399; i++) write_sample($urandom, $urandom_range(3, 6));
      repeat (20) @(posedge clk_in);
      #1;
      check("s4_no_early_burst", bursts_seen - b0, 0);
      check("s4_idle", busy_out, 0);
      write_sample($urandom, 3);
      wait_drain(2000);
      check("s4_bursts", bursts_seen - b0, 1);
      check("s4_frame_count", frame_count_out, 1);

      // Long run covering ring address wrap.
      apply_reset();
      b0 = bursts_seen;
      for (int i = 0; i < 2000; i++) write_sample($urandom, $urandom_range(3, 6));
      wait_drain(2000);
      check("s5_bursts", bursts_seen - b0, 11);
      check("s5_frame_count", frame_count_out, 11);
      check("s5_overrun", overrun_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
